// File: rtl/axi_slave_mem_pkg.sv
//------------------------------------------------------------------------------
// Module : axi_slave_mem_pkg
// Brief  : Shared AXI3 definitions for the slave memory: burst types, lock and
//          protection codes, response codes, the captured address-channel
//          record and the burst address-advance helper.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package axi_slave_mem_pkg;

  // Burst types
  localparam logic [1:0] c_BURST_FIXED = 2'b00;
  localparam logic [1:0] c_BURST_INCR  = 2'b01;
  localparam logic [1:0] c_BURST_WRAP  = 2'b10;
  localparam logic [1:0] c_BURST_RSVD  = 2'b11;

  // Burst length limits (AXI3: 1..16 beats, encoded as beats-1)
  localparam int         c_BURST_MAX_BEATS = 16;
  localparam int         c_LEN_WIDTH       = 4;

  // Lock codes
  localparam logic [1:0] c_LOCK_NORMAL    = 2'b00;
  localparam logic [1:0] c_LOCK_EXCLUSIVE = 2'b01;
  localparam logic [1:0] c_LOCK_LOCKED    = 2'b10;

  // Protection bits
  localparam logic [2:0] c_PROT_PRIVILEGED = 3'b001;
  localparam logic [2:0] c_PROT_NONSECURE  = 3'b010;
  localparam logic [2:0] c_PROT_INSTR      = 3'b100;

  // Response codes
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  // Address-channel fields held for the life of one transaction
  typedef struct packed {
    logic [3:0]             id;
    logic [31:0]            addr;
    logic [c_LEN_WIDTH-1:0] len;
    logic [2:0]             size;
    logic [1:0]             burst;
  } axi_addr_t;

  // Address of the beat following 'addr'. For WRAP the low bits inside the
  // wrap window advance and roll over while the bits above it stay put, which
  // keeps the address inside the aligned (len+1)*step window.
  function automatic logic [31:0] axi_next_addr(input logic [31:0]            addr,
                                                input logic [2:0]             size,
                                                input logic [c_LEN_WIDTH-1:0] len,
                                                input logic [1:0]             burst);
    logic [31:0] step;
    logic [31:0] incr;
    logic [31:0] wrap_mask;
    logic [31:0] nxt;
    step      = 32'd1 << size;
    incr      = addr + step;
    wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      c_BURST_INCR: nxt = incr;
      c_BURST_WRAP: nxt = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:      nxt = addr;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_slave_mem_ram.sv
//------------------------------------------------------------------------------
// Module : axi_slave_mem_ram
// Brief  : 2**ADDR_WIDTH x 32-bit simple dual-port RAM. One write port with
//          per-byte enables, one read port with a registered output (1-cycle
//          latency). A read and a write to the same word in the same cycle
//          returns the old contents. Contents are not reset.
// Ports  : clk_i    - clock
//          we_i     - write enable
//          waddr_i  - write word index
//          wbe_i    - byte-lane enables for the write
//          wdata_i  - write data
//          re_i     - read enable (output register loads when high)
//          raddr_i  - read word index
//          rdata_o  - registered read data, held while re_i is low
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_slave_mem_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [3:0]            wbe_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  // One byte-wide array per lane so each lane is an independent memory with
  // its own enable; no partial-word read-modify-write is needed.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [c_DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i && wbe_i[gi]) begin
        mem_q[waddr_i] <= wdata_i[8*gi +: 8];
      end
      if (re_i) begin
        rd_q <= mem_q[raddr_i];
      end
    end

    assign rdata_o[8*gi +: 8] = rd_q;
  end

endmodule

`default_nettype wire

// File: rtl/axi_slave_mem.sv
//------------------------------------------------------------------------------
// Module : axi_slave_mem
// Brief  : AXI3 slave memory backed by a 32-bit byte-strobed word RAM.
//          Independent write and read FSMs, one outstanding transaction per
//          direction, 1..16 beat FIXED/INCR/WRAP bursts. awready/wready/
//          arready are registered single-cycle pulses.
// Params : ADDR_WIDTH - word-address bits, depth = 2**ADDR_WIDTH words
//          BASE_ADDR  - byte address of word 0
// Ports  : aclk, aresetn (async, active-low)
//          AW channel : awid awadr awlen awsize awburst awlock awcache awprot
//                       awvalid -> awready
//          W channel  : wid wrdata wstrb wlast wvalid -> wready
//          B channel  : bid bresp bvalid <- bready
//          AR channel : arid araddr arlen arsize arburst arlock arcache arprot
//                       arvalid -> arready
//          R channel  : rid rdata rresp rlast rvalid <- rready
// Config : AXI_SLAVE_RANGE_CHECK_EN - when defined, a transaction whose start
//          address is outside [BASE_ADDR, BASE_ADDR+4*depth) answers SLVERR,
//          suppresses writes and returns zero read data. When undefined the
//          word index aliases modulo depth.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awadr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wrdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  // R_READ is the cycle the RAM read is issued; R_DATA presents the beat.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_READ = 2'd2,
    R_DATA = 2'd3
  } rd_state_e;

  //--------------------------------------------------------------------------
  // Start-address range check
  //--------------------------------------------------------------------------
  logic w_aw_oor;
  logic w_ar_oor;

`ifdef AXI_SLAVE_RANGE_CHECK_EN
  // 33-bit difference: bit 32 is the borrow, i.e. addr below BASE_ADDR.
  function automatic logic f_out_of_range(input logic [31:0] addr);
    logic [32:0] diff;
    logic [31:0] hi;
    diff = {1'b0, addr} - {1'b0, BASE_ADDR};
    hi   = diff[31:0] >> (ADDR_WIDTH + 2);
    return diff[32] || (hi != 32'd0);
  endfunction

  assign w_aw_oor = f_out_of_range(awadr);
  assign w_ar_oor = f_out_of_range(araddr);
`else
  assign w_aw_oor = 1'b0;
  assign w_ar_oor = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Write path
  //--------------------------------------------------------------------------
  wr_state_e wr_state_q, wr_state_d;
  axi_addr_t wr_ax_q, wr_ax_d;
  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic       wr_err_q, wr_err_d;
  logic       wr_supp_q, wr_supp_d;
  logic       awready_q, awready_d;
  logic       wready_q, wready_d;
  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;

  logic       w_ram_we;
  logic       w_wr_final;
  logic       w_wlast_bad;

  assign w_wr_final  = (wr_cnt_q == wr_ax_q.len);
  assign w_wlast_bad = (wlast != w_wr_final);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_ax_d    = wr_ax_q;
    wr_cnt_d   = wr_cnt_q;
    wr_err_d   = wr_err_q;
    wr_supp_d  = wr_supp_q;
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    w_ram_we   = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        if (awvalid) begin
          awready_d  = 1'b1;
          wr_state_d = W_ADDR;
        end
      end
      // awready is high in this cycle, so this is the AW handshake cycle.
      W_ADDR: begin
        wr_ax_d    = '{id: awid, addr: awadr, len: awlen, size: awsize, burst: awburst};
        wr_cnt_d   = 4'd0;
        wr_supp_d  = (awburst == c_BURST_RSVD) || w_aw_oor;
        wr_err_d   = (awburst == c_BURST_RSVD) || w_aw_oor;
        bresp_d    = c_RESP_OKAY;
        wr_state_d = W_DATA;
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          w_ram_we = !wr_supp_q;
          if (w_wr_final) begin
            bvalid_d   = 1'b1;
            bresp_d    = (wr_err_q || w_wlast_bad) ? c_RESP_SLVERR : c_RESP_OKAY;
            wr_state_d = W_RESP;
          end else begin
            wr_err_d     = wr_err_q || w_wlast_bad;
            wr_cnt_d     = wr_cnt_q + 4'd1;
            wr_ax_d.addr = axi_next_addr(wr_ax_q.addr, wr_ax_q.size, wr_ax_q.len, wr_ax_q.burst);
          end
        end else if (wvalid) begin
          // wready_q is low here, so this always produces a fresh 0->1 edge.
          wready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      wr_ax_q    <= '0;
      wr_cnt_q   <= 4'd0;
      wr_err_q   <= 1'b0;
      wr_supp_q  <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      wr_state_q <= wr_state_d;
      wr_ax_q    <= wr_ax_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
      wr_supp_q  <= wr_supp_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = wr_ax_q.id;

  //--------------------------------------------------------------------------
  // Read path
  //--------------------------------------------------------------------------
  rd_state_e  rd_state_q, rd_state_d;
  axi_addr_t  rd_ax_q, rd_ax_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic       rd_err_q, rd_err_d;
  logic       arready_q, arready_d;
  logic       rvalid_q, rvalid_d;
  logic       rlast_q, rlast_d;
  logic [1:0] rresp_q, rresp_d;

  logic       w_ram_re;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_ax_d    = rd_ax_q;
    rd_cnt_d   = rd_cnt_q;
    rd_err_d   = rd_err_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    w_ram_re   = 1'b0;

    case (rd_state_q)
      R_IDLE: begin
        if (arvalid) begin
          arready_d  = 1'b1;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        rd_ax_d    = '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
        rd_cnt_d   = 4'd0;
        rd_err_d   = (arburst == c_BURST_RSVD) || w_ar_oor;
        rd_state_d = R_READ;
      end
      R_READ: begin
        w_ram_re   = 1'b1;
        rvalid_d   = 1'b1;
        rlast_d    = (rd_cnt_q == rd_ax_q.len);
        rresp_d    = rd_err_q ? c_RESP_SLVERR : c_RESP_OKAY;
        rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_cnt_d     = rd_cnt_q + 4'd1;
            rd_ax_d.addr = axi_next_addr(rd_ax_q.addr, rd_ax_q.size, rd_ax_q.len, rd_ax_q.burst);
            rd_state_d   = R_READ;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rd_ax_q    <= '0;
      rd_cnt_q   <= 4'd0;
      rd_err_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'b00;
    end else begin
      rd_state_q <= rd_state_d;
      rd_ax_q    <= rd_ax_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_err_q   <= rd_err_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
    end
  end

  //--------------------------------------------------------------------------
  // RAM
  //--------------------------------------------------------------------------
  logic [31:0]           w_wr_off;
  logic [31:0]           w_rd_off;
  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [31:0]           w_ram_rdata;

  // Dropping the bits above ADDR_WIDTH+1 gives the modulo-depth aliasing.
  assign w_wr_off = wr_ax_q.addr - BASE_ADDR;
  assign w_rd_off = rd_ax_q.addr - BASE_ADDR;
  assign w_wr_idx = w_wr_off[ADDR_WIDTH+1:2];
  assign w_rd_idx = w_rd_off[ADDR_WIDTH+1:2];

  axi_slave_mem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (w_ram_we),
    .waddr_i (w_wr_idx),
    .wbe_i   (wstrb),
    .wdata_i (wrdata),
    .re_i    (w_ram_re),
    .raddr_i (w_rd_idx),
    .rdata_o (w_ram_rdata)
  );

  // The RAM output register is not reset; gating with rvalid makes rdata
  // drop to zero together with the other outputs on reset. Error beats
  // (reserved burst, out of range) carry zero data.
  assign rdata  = (rvalid_q && !rd_err_q) ? w_ram_rdata : 32'd0;
  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;
  assign rresp  = rresp_q;
  assign rid    = rd_ax_q.id;
  assign arready = arready_q;

  // Inputs that carry no meaning for this memory, plus the address offset
  // bits that fall outside the word index.
  logic w_unused;
  assign w_unused = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid,
                      w_wr_off, w_rd_off};

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
//------------------------------------------------------------------------------
// Module : tb_axi_slave_mem
// Brief  : Self-checking directed bench for axi_slave_mem. Expected write
//          responses and read beats are queued when stimulus is issued and
//          popped when the DUT presents them.
// Config : AXI_SLAVE_RANGE_CHECK_EN selects the expected outcome of the
//          out-of-range write.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_slave_mem;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid;
  logic [31:0] awadr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wrdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 aclk = ~aclk;

  axi_slave_mem #(
    .ADDR_WIDTH (10),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .aclk    (aclk),    .aresetn (aresetn),
    .awid    (awid),    .awadr   (awadr),   .awlen   (awlen),   .awsize  (awsize),
    .awburst (awburst), .awlock  (awlock),  .awcache (awcache), .awprot  (awprot),
    .awvalid (awvalid), .awready (awready),
    .wid     (wid),     .wrdata  (wrdata),  .wstrb   (wstrb),   .wlast   (wlast),
    .wvalid  (wvalid),  .wready  (wready),
    .bid     (bid),     .bresp   (bresp),   .bvalid  (bvalid),  .bready  (bready),
    .arid    (arid),    .araddr  (araddr),  .arlen   (arlen),   .arsize  (arsize),
    .arburst (arburst), .arlock  (arlock),  .arcache (arcache), .arprot  (arprot),
    .arvalid (arvalid), .arready (arready),
    .rid     (rid),     .rdata   (rdata),   .rresp   (rresp),   .rlast   (rlast),
    .rvalid  (rvalid),  .rready  (rready)
  );

  // Scoreboard entries: read beat {id, resp, last, data}; write resp {id, resp}
  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic [31:0] data;
  } rbeat_t;

  rbeat_t     r_q[$];
  logic [5:0] b_q[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] wd[16];
  logic [3:0]  ws[16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic rbeat_t rb(input logic [3:0] id, input logic [1:0] resp,
                                input logic last, input logic [31:0] data);
    rbeat_t b;
    b.id = id; b.resp = resp; b.last = last; b.data = data;
    return b;
  endfunction

  // Issues AW then all W beats (size 4 bytes). Called and returns at posedge+1.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst,
                           input bit early_last, input logic [1:0] exp_resp);
    int n;
    b_q.push_back({id, exp_resp});
    awid = id; awadr = addr; awlen = len; awsize = 3'd2; awburst = burst;
    awvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!awready && n < 20);
    if (!awready) begin tmo("aw_handshake"); awvalid = 1'b0; return; end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wid    = id;
      wrdata = wd[i];
      wstrb  = ws[i];
      wlast  = early_last ? (i == 0) : (i == int'(len));
      wvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!wready && n < 20);
      if (!wready) begin tmo("w_handshake"); wvalid = 1'b0; return; end
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  // Waits for the B response, optionally with bready held low for 'hold'
  // cycles (caller drives bready before axi_write). Returns at posedge+1.
  task automatic collect_b(input int hold);
    int n;
    logic [5:0] exp;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bvalid && n < 20);
    if (!bvalid) begin tmo("b_valid"); bready = 1'b1; return; end
    exp = b_q.pop_front();
    chk("b_id_resp", {bid, bresp}, exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge aclk);
      chk("b_hold_stable", {bvalid, bid, bresp}, {1'b1, exp});
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("b_drop", bvalid, 1'b0);
    @(posedge aclk); #1;
  endtask

  // Issues AR and consumes the beats, checking data and beat latency.
  // With hold_last the final beat is left presented with rready low.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst,
                          input bit hold_last);
    int n;
    int lat;
    rbeat_t exp;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst;
    rready  = 1'b1;
    arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < 20);
    if (!arready) begin tmo("ar_handshake"); arvalid = 1'b0; return; end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (hold_last && i == int'(len)) rready = 1'b0;
      lat = 0;
      do begin @(negedge aclk); lat++; end while (!rvalid && lat < 20);
      if (!rvalid) begin tmo("r_valid"); return; end
      chk("r_latency", 64'(lat), 64'd2);
      exp = r_q.pop_front();
      chk("r_beat", {rid, rresp, rlast, rdata}, exp);
      if (hold_last && i == int'(len)) return;
      @(posedge aclk); #1;
    end
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awadr = '0; awlen = '0; awsize = '0; awburst = '0;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wrdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
    chk("rst_resp", {bid, bresp, rid, rresp, rdata}, 44'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single write / single read
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    axi_write(4'h0, 32'h10, 4'd0, 2'b01, 1'b0, 2'b00);
    collect_b(0);
    r_q.push_back(rb(4'h0, 2'b00, 1'b1, 32'hDEAD_BEEF));
    axi_read(4'h0, 32'h10, 4'd0, 2'b01, 1'b0);

    // Byte strobes
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    axi_write(4'h3, 32'h20, 4'd0, 2'b01, 1'b0, 2'b00);
    collect_b(0);
    wd[0] = 32'h0000_00AA; ws[0] = 4'h1;
    axi_write(4'h3, 32'h20, 4'd0, 2'b01, 1'b0, 2'b00);
    collect_b(0);
    r_q.push_back(rb(4'h6, 2'b00, 1'b1, 32'hFFFF_FFAA));
    axi_read(4'h6, 32'h20, 4'd0, 2'b01, 1'b0);

    // INCR write of 4 beats, WRAP read starting mid-window
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write(4'h2, 32'h100, 4'd3, 2'b01, 1'b0, 2'b00);
    collect_b(0);
    r_q.push_back(rb(4'h9, 2'b00, 1'b0, 32'd3));
    r_q.push_back(rb(4'h9, 2'b00, 1'b0, 32'd4));
    r_q.push_back(rb(4'h9, 2'b00, 1'b0, 32'd1));
    r_q.push_back(rb(4'h9, 2'b00, 1'b1, 32'd2));
    axi_read(4'h9, 32'h108, 4'd3, 2'b10, 1'b0);

    // Early wlast -> SLVERR, response held with bready low
    wd[0] = 32'h55; wd[1] = 32'h66; ws[0] = 4'hF; ws[1] = 4'hF;
    bready = 1'b0;
    axi_write(4'hA, 32'h200, 4'd1, 2'b01, 1'b1, 2'b10);
    collect_b(5);
    r_q.push_back(rb(4'h1, 2'b00, 1'b0, 32'h55));
    r_q.push_back(rb(4'h1, 2'b00, 1'b1, 32'h66));
    axi_read(4'h1, 32'h200, 4'd1, 2'b01, 1'b0);

    // Reserved burst: write suppressed, read beats are SLVERR with zero data
    wd[0] = 32'h0; ws[0] = 4'hF;
    axi_write(4'h4, 32'h10, 4'd0, 2'b11, 1'b0, 2'b10);
    collect_b(0);
    r_q.push_back(rb(4'h4, 2'b00, 1'b1, 32'hDEAD_BEEF));
    axi_read(4'h4, 32'h10, 4'd0, 2'b01, 1'b0);
    r_q.push_back(rb(4'h7, 2'b10, 1'b0, 32'd0));
    r_q.push_back(rb(4'h7, 2'b10, 1'b1, 32'd0));
    axi_read(4'h7, 32'h100, 4'd1, 2'b11, 1'b0);

    // FIXED burst: both beats land on the same word
    wd[0] = 32'hA; wd[1] = 32'hB; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(4'h5, 32'h300, 4'd1, 2'b00, 1'b0, 2'b00);
    collect_b(0);
    r_q.push_back(rb(4'h8, 2'b00, 1'b0, 32'hB));
    r_q.push_back(rb(4'h8, 2'b00, 1'b1, 32'hB));
    axi_read(4'h8, 32'h300, 4'd1, 2'b00, 1'b0);

    // Start address one past the end of a 1024-word memory
    wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
    axi_write(4'h1, 32'h0, 4'd0, 2'b01, 1'b0, 2'b00);
    collect_b(0);
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
`ifdef AXI_SLAVE_RANGE_CHECK_EN
    axi_write(4'hC, 32'h1000, 4'd0, 2'b01, 1'b0, 2'b10);
    collect_b(0);
    r_q.push_back(rb(4'hD, 2'b00, 1'b1, 32'hCAFE_F00D));
`else
    axi_write(4'hC, 32'h1000, 4'd0, 2'b01, 1'b0, 2'b00);
    collect_b(0);
    r_q.push_back(rb(4'hD, 2'b00, 1'b1, 32'h1234_5678));
`endif
    axi_read(4'hD, 32'h0, 4'd0, 2'b01, 1'b0);

    // Reset in the middle of a read burst, final beat stalled
    r_q.push_back(rb(4'hE, 2'b00, 1'b0, 32'd1));
    r_q.push_back(rb(4'hE, 2'b00, 1'b0, 32'd2));
    r_q.push_back(rb(4'hE, 2'b00, 1'b0, 32'd3));
    r_q.push_back(rb(4'hE, 2'b00, 1'b1, 32'd4));
    axi_read(4'hE, 32'h100, 4'd3, 2'b01, 1'b1);
    @(posedge aclk); #1;
    chk("r_stall_stable", {rvalid, rlast, rid, rdata}, {1'b1, 1'b1, 4'hE, 32'd4});
    #2;
    aresetn = 1'b0;
    #1;
    chk("r_async_reset", {rvalid, rlast, arready, rresp, rdata}, 37'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rready  = 1'b1;
    @(posedge aclk); #1;
    r_q.push_back(rb(4'hB, 2'b00, 1'b1, 32'hFFFF_FFAA));
    axi_read(4'hB, 32'h20, 4'd0, 2'b01, 1'b0);

    chk("scoreboard_empty", 64'(r_q.size() + b_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
